// File: rtl/if_stage.sv
// Instruction fetch stage: a PC register driving a combinational instruction memory,
// with a one-entry output register, a valid/ready handshake to decode and a redirect flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        xfer_s;
  logic        load_s;
  logic [31:0] pc_plus4_s;

  // Next-state, next-PC and output-register computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    opc_d      = opc_q;
    opc4_d     = opc4_q;
    cnt_d      = cnt_q;
    load_s     = 1'b0;
    pc_plus4_s = pc_q + 32'd4;
    xfer_s     = (state_q == S_FULL) && out_ready;

    // A transfer counts even in a redirect cycle.
    if (xfer_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (redirect_valid) begin
      state_d = S_EMPTY;
      pc_d    = redirect_target & 32'hFFFF_FFFC;
    end else begin
      case (state_q)
        S_EMPTY: load_s = 1'b1;
        S_FULL: begin
          if (out_ready) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          load_s  = 1'b0;
        end
      endcase

      if (load_s) begin
        state_d = S_FULL;
        inst_d  = imem_inst;
        opc_d   = pc_q;
        opc4_d  = pc_plus4_s;
        pc_d    = pc_plus4_s;
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      opc_q   <= 32'd0;
      opc4_q  <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (state_q == S_FULL);
  assign out_inst    = inst_q;
  assign out_pc      = opc_q;
  assign out_pc4     = opc4_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the expected fetch stream is queued whenever a stream
// starts (reset or redirect); a negedge monitor pops and compares every transfer.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pc4, fetch_count;

  logic        w_rst = 1'b1;
  logic [31:0] w_addr, w_inst;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_out_inst, w_out_pc, w_out_pc4, w_count;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] model_count = 32'd0;
  logic [31:0] start_pc = 32'd0;
  bit          fresh = 1'b0;
  bit          w_done = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    else if (a == 32'h4) return 32'h2002_0006;
    else return (a ^ 32'hA5A5_5A5A) * 32'h0001_0003 + 32'h1234_5678;
  endfunction

  assign imem_inst = mem_word(imem_addr);
  assign w_inst    = mem_word(w_addr);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc4(out_pc4), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_inst(w_inst),
    .redirect_valid(1'b0), .redirect_target(32'd0),
    .out_valid(w_valid), .out_ready(w_ready), .out_inst(w_out_inst),
    .out_pc(w_out_pc), .out_pc4(w_out_pc4), .fetch_count(w_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every stream is a run of consecutive word addresses from its start, wrapping mod 2^32.
  task automatic push_stream(input logic [31:0] s);
    exp_t        e;
    logic [31:0] p;
    exp_q.delete();
    p = s;
    for (int i = 0; i < 48; i++) begin
      e.inst = mem_word(p);
      e.pc   = p;
      e.pc4  = p + 32'd4;
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic drive_cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
    rst             = r;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(posedge clk);
    #1;
    if (r) begin
      start_pc    = 32'd0;
      model_count = 32'd0;
      fresh       = 1'b1;
      push_stream(start_pc);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_inst", out_inst, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_pc4", out_pc4, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
    end else if (rv) begin
      start_pc = {tgt[31:2], 2'b00};
      fresh    = 1'b1;
      push_stream(start_pc);
      chk("redir_valid", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, start_pc);
    end else if (fresh) begin
      fresh = 1'b0;
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      chk("first_pc", out_pc, start_pc);
    end
  endtask

  // Monitor: handshake transfers against the queue, fetch_count, and stall hold.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] s_inst, s_pc, s_pc4, s_addr;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_inst", out_inst, s_inst);
          chk("hold_pc", out_pc, s_pc);
          chk("hold_pc4", out_pc4, s_pc4);
          chk("hold_addr", imem_addr, s_addr);
        end
        chk("fetch_count", fetch_count, model_count);
        if (out_valid === 1'b1 && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL xfer_unexpected: got pc %h expected no transfer", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc", out_pc, e.pc);
            chk("xfer_pc4", out_pc4, e.pc4);
            chk("xfer_inst", out_inst, e.inst);
          end
          model_count = model_count + 32'd1;
        end
        prev_stall = (out_valid === 1'b1) && !out_ready && !redirect_valid;
        s_inst = out_inst;
        s_pc   = out_pc;
        s_pc4  = out_pc4;
        s_addr = imem_addr;
      end
    end
  end

  // Wrap-around instance: RESET_PC at the top of the address space.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    w_rst = 1'b0;
    chk("w_idle_valid", {31'd0, w_valid}, 32'd0);
    chk("w_idle_addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("w_first_valid", {31'd0, w_valid}, 32'd1);
    chk("w_first_pc", w_out_pc, 32'hFFFF_FFFC);
    chk("w_first_pc4", w_out_pc4, 32'h0000_0000);
    chk("w_first_inst", w_out_inst, mem_word(32'hFFFF_FFFC));
    chk("w_next_addr", w_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("w_second_pc", w_out_pc, 32'h0000_0000);
    chk("w_second_pc4", w_out_pc4, 32'h0000_0004);
    chk("w_count", w_count, 32'd1);
    w_done = 1'b1;
  end

  initial begin
    int          age;
    int          roll;
    logic        r, rv, rdy;
    logic [31:0] tgt;

    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("d_inst0", out_inst, 32'h2001_0005);
    chk("d_pc4_0", out_pc4, 32'd4);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("d_inst1", out_inst, 32'h2002_0006);
    chk("d_pc1", out_pc, 32'd4);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("d_count2", fetch_count, 32'd2);
    chk("d_pc2", out_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      chk("d_stall_addr", imem_addr, 32'hC);
      chk("d_stall_pc", out_pc, 32'h8);
      chk("d_stall_count", fetch_count, 32'd2);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("d_after_stall", out_pc, 32'hC);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h1C);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("d_redir_pc", out_pc, 32'h1C);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h17);
    chk("d_misalign", imem_addr, 32'h14);
    chk("d_redir_xfer_count", fetch_count, 32'd4);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);

    age = 0;
    for (int c = 0; c < 1500; c++) begin
      age++;
      roll = $urandom_range(0, 99);
      r    = (roll < 2);
      rv   = ((roll >= 2) && (roll < 12)) || (age >= 40);
      rdy  = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      else tgt = $urandom;
      if (r || rv) age = 0;
      drive_cycle(r, rdy, rv, tgt);
    end

    n_cmp++;
    if (!w_done) begin
      n_mis++;
      $display("FAIL w_done: got 0 expected 1");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset; bits [1:0] are zero.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 imem_addr  output  32  byte fetch address to the combinational instruction memory.
REQ-006 imem_inst  input  32  instruction word returned for imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump/jr taken this cycle; flushes the stage.
REQ-008 redirect_target  input  32  byte address of the new fetch stream.
REQ-009 out_valid  output  1  out_inst/out_pc/out_pc4 hold a valid fetched instruction.
REQ-010 out_ready  input  1  decode stage accepts the instruction this cycle.
REQ-011 out_inst  output  32  registered instruction word.
REQ-012 out_pc  output  32  byte address of out_inst.
REQ-013 out_pc4  output  32  out_pc + 4, used as the jal link value and branch base.
REQ-014 fetch_count  output  32  number of instructions accepted by decode since reset.

Function
REQ-015 The stage SHALL hold a 32-bit PC register, and imem_addr SHALL equal the PC combinationally.
REQ-016 Handshake: a transfer occurs in a cycle where out_valid=1 and out_ready=1.
REQ-017 Load condition: (out_valid=0 or out_ready=1) and redirect_valid=0.
REQ-018 When the load condition holds, at the clock edge: out_inst<=imem_inst, out_pc<=PC, out_pc4<=PC+4, out_valid<=1, PC<=PC+4 (single-cycle fetch latency).
REQ-019 Stall: when out_valid=1, out_ready=0 and redirect_valid=0, PC, out_valid, out_inst, out_pc and out_pc4 SHALL hold their values.
REQ-020 Once asserted, out_valid SHALL NOT deassert without a transfer, a redirect or a reset.
REQ-021 Redirect: when redirect_valid=1, at the clock edge: PC<={redirect_target[31:2],2'b00} and out_valid<=0, regardless of out_ready or stall state.
REQ-022 Redirect SHALL have priority over both the stall and the load conditions.
REQ-023 out_inst/out_pc/out_pc4 MAY hold stale values while out_valid=0.
REQ-024 The first instruction of the new stream SHALL appear with out_valid=1 one cycle after the redirect edge.
REQ-025 A transfer coincident with redirect_valid=1 SHALL still count; no other data from that cycle is loaded.
REQ-026 PC+4 SHALL wrap modulo 2^32: PC=32'hFFFF_FFFC advances to 32'h0000_0000, and out_pc4 wraps the same way.
REQ-027 fetch_count SHALL increment by 1 on every transfer and wrap from 32'hFFFF_FFFF to 0.
REQ-028 Stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-029 EMPTY->FULL on load; FULL->FULL on transfer+load or stall; any->EMPTY on redirect.
REQ-030 The stage SHALL have no combinational path from out_ready or redirect_valid to any output.

Reset
REQ-031 While rst=1 at a clock edge: PC<=RESET_PC, out_valid<=0, out_inst<=0, out_pc<=0, out_pc4<=0, fetch_count<=0.
REQ-032 rst SHALL override redirect_valid and out_ready.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.
REQ-034 In the first cycle after rst deasserts: imem_addr=RESET_PC and out_valid=0.
REQ-035 The cycle after that: out_valid=1 and out_pc=RESET_PC.

Verification
REQ-036 Reset then streaming: memory word at 0x0=32'h20010005 and at 0x4=32'h20020006, out_ready=1, RESET_PC=0 -> out_valid rises 1 cycle after reset release with out_inst=32'h20010005/out_pc=0/out_pc4=4, then 32'h20020006/out_pc=4; fetch_count=2 after two transfers.
REQ-037 Stall: out_ready=0 for 3 cycles while holding out_pc=0x8 -> PC stays 0xC, out_* unchanged, fetch_count unchanged; out_ready=1 -> out_pc=0xC next cycle.
REQ-038 Redirect during stall: out_valid=1, out_ready=0, redirect_valid=1, target=0x1C -> next cycle out_valid=0 and imem_addr=0x1C; following cycle out_pc=0x1C.
REQ-039 Misaligned redirect: target=0x17 -> PC=0x14.
REQ-040 Wrap: RESET_PC=32'hFFFF_FFFC -> first out_pc=32'hFFFF_FFFC, out_pc4=0; next out_pc=0.
REQ-041 Reset mid-stall: assert rst with out_valid=1, out_ready=0 -> next cycle out_valid=0, fetch_count=0, imem_addr=RESET_PC.
